// File: rtl/fifo_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : fifo_pkg                                                   |
// | Description : Shared sizing constants and pointer type for the FIFO      |
// |               pointer/flag controller (8x8 APB<->I2C data-path array).   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

  // Address bits of the storage array; depth follows as a power of two.
  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

  // Wrap pointer: low bits address the array, MSB distinguishes full from empty.
  typedef logic [FIFO_ADDR_WIDTH:0] fifo_ptr_t;

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_ptr.sv
// +--------------------------------------------------------------------------+
// | Module      : fifo_ptr                                                   |
// | Description : ADDR_WIDTH+1-bit wrap pointer with increment enable and    |
// |               synchronous clear (clear has priority over increment).     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  en_i,
  output logic [ADDR_WIDTH:0]   ptr_o
);

  localparam logic [ADDR_WIDTH:0] C_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] ptr_q;
  logic [ADDR_WIDTH:0] ptr_d;

  // Next pointer: flush wins, otherwise advance and wrap through 2*DEPTH naturally.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = ptr_q + C_ONE;
    end
  end

  // Pointer register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : fifo_ptr

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : fifo_ctrl                                                  |
// | Description : Single-clock pointer/flag controller for a first-word      |
// |               fall-through FIFO array. Generates array addresses, write  |
// |               enable/gate, full/empty/almost flags and sticky errors.    |
// |               Optional macro FIFO_CTRL_LEVEL_EN adds level output and a  |
// |               registered programmable threshold flag.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  output logic                  mem_wr_en,
  output logic                  mem_full,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
`ifdef FIFO_CTRL_LEVEL_EN
  output logic [ADDR_WIDTH:0]   level,
  input  logic [ADDR_WIDTH:0]   thresh,
  output logic                  thresh_hit,
`endif
  output logic                  underflow
);

  // Threshold constants sized to the count so comparisons are width-exact.
  localparam logic [ADDR_WIDTH:0] C_AF_THR = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_AE_THR = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH:0] wr_ptr_w;
  logic [ADDR_WIDTH:0] rd_ptr_w;
  logic [ADDR_WIDTH:0] count_w;
  logic                full_w;
  logic                empty_w;
  logic                push_ok_w;
  logic                pop_ok_w;

  logic                overflow_q;
  logic                overflow_d;
  logic                underflow_q;
  logic                underflow_d;

  // Accept decisions use only the flags from registered state, so a
  // simultaneous push+pop at full still rejects the push (and vice versa).
  assign push_ok_w = push & ~full_w & ~clr;
  assign pop_ok_w  = pop  & ~empty_w & ~clr;

  fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .en_i  (push_ok_w),
    .ptr_o (wr_ptr_w)
  );

  fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .en_i  (pop_ok_w),
    .ptr_o (rd_ptr_w)
  );

  // Flag decode from the pointer registers only.
  always_comb begin
    count_w      = wr_ptr_w - rd_ptr_w;
    empty_w      = (wr_ptr_w == rd_ptr_w);
    full_w       = (wr_ptr_w[ADDR_WIDTH] != rd_ptr_w[ADDR_WIDTH]) &&
                   (wr_ptr_w[ADDR_WIDTH-1:0] == rd_ptr_w[ADDR_WIDTH-1:0]);
    almost_full  = (count_w >= C_AF_THR);
    almost_empty = (count_w <= C_AE_THR);
  end

  // Sticky error next-state: set on a rejected request, cleared only by flush.
  always_comb begin
    overflow_d  = overflow_q  | (push & full_w);
    underflow_d = underflow_q | (pop & empty_w);
    if (clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // Sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_CTRL_LEVEL_EN
  logic thresh_hit_q;

  // Threshold compare is registered, giving one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_hit_q <= 1'b0;
    end else begin
      thresh_hit_q <= (count_w >= thresh);
    end
  end

  assign level      = count_w;
  assign thresh_hit = thresh_hit_q;
`endif

  assign mem_wr_en = push;
  assign mem_full  = full_w;
  assign wr_addr   = wr_ptr_w[ADDR_WIDTH-1:0];
  assign rd_addr   = rd_ptr_w[ADDR_WIDTH-1:0];
  assign full      = full_w;
  assign empty     = empty_w;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule : fifo_ctrl

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_ctrl                                               |
// | Description : Directed self-checking bench for fifo_ctrl paired with a   |
// |               behavioural 8x8 fall-through array. Honours the optional   |
// |               FIFO_CTRL_LEVEL_EN macro.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       push;
  logic       pop;
  logic [7:0] din;
  logic       mem_wr_en;
  logic       mem_full;
  logic [2:0] wr_addr;
  logic [2:0] rd_addr;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;
`ifdef FIFO_CTRL_LEVEL_EN
  logic [3:0] level;
  logic [3:0] thresh;
  logic       thresh_hit;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:7];
  logic [7:0] popped;

  fifo_ctrl #(
    .ADDR_WIDTH (3),
    .AF_LEVEL   (6),
    .AE_LEVEL   (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .push         (push),
    .pop          (pop),
    .mem_wr_en    (mem_wr_en),
    .mem_full     (mem_full),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
`ifdef FIFO_CTRL_LEVEL_EN
    .level        (level),
    .thresh       (thresh),
    .thresh_hit   (thresh_hit),
`endif
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural storage array: writes gated by mem_full, combinational read.
  always @(posedge clk) begin
    if (mem_wr_en && !mem_full) mem[wr_addr] <= din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Held entry count from the outputs: low-bit distance, with full meaning 8.
  function automatic logic [31:0] cnt();
    logic [2:0] d;
    d = wr_addr - rd_addr;
    return full ? 32'd8 : {29'd0, d};
  endfunction

  // One clock: drive inputs, capture fall-through data before the edge, sample #1 after.
  task automatic cyc(input logic p, input logic q, input logic [7:0] d);
    push   = p;
    pop    = q;
    din    = d;
    #1;
    popped = mem[rd_addr];
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;
`ifdef FIFO_CTRL_LEVEL_EN
    thresh = 4'd4;
`endif
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. Asynchronous reset mid-stream, observed without any clock edge.
    cyc(1'b1, 1'b0, 8'hA0);
    cyc(1'b1, 1'b0, 8'hA1);
    cyc(1'b1, 1'b0, 8'hA2);
    push = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_aempty", {31'd0, almost_empty}, 32'd1);
    chk("rst_afull", {31'd0, almost_full}, 32'd0);
    chk("rst_wr_addr", {29'd0, wr_addr}, 32'd0);
    chk("rst_rd_addr", {29'd0, rd_addr}, 32'd0);
    chk("rst_errs", {30'd0, overflow, underflow}, 32'd0);
    push = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 2. Fill with 0x10..0x17, then overflow attempt with 0xFF.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h10 + i));
      chk($sformatf("fill_afull_%0d", i), {31'd0, almost_full}, (i >= 5) ? 32'd1 : 32'd0);
      chk($sformatf("fill_full_%0d", i), {31'd0, full}, (i == 7) ? 32'd1 : 32'd0);
    end
    chk("fill_memfull", {31'd0, mem_full}, 32'd1);
    cyc(1'b1, 1'b0, 8'hFF);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_wr_addr", {29'd0, wr_addr}, 32'd0);
    chk("ovf_slot0", {24'd0, mem[0]}, 32'h10);

    // 3. Drain eight in order, then underflow attempt.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk($sformatf("drain_data_%0d", i), {24'd0, popped}, 32'(8'h10 + i));
      chk($sformatf("drain_aempty_%0d", i), {31'd0, almost_empty}, (i >= 6) ? 32'd1 : 32'd0);
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("udf_set", {31'd0, underflow}, 32'd1);
    chk("udf_rd_addr", {29'd0, rd_addr}, 32'd0);
    chk("udf_ovf_sticky", {31'd0, overflow}, 32'd1);

    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("clr1_errs", {30'd0, overflow, underflow}, 32'd0);

    // 4. Wrap: keep three entries while streaming 20 push+pop cycles.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b1, 8'(8'h23 + k));
      chk($sformatf("wrap_data_%0d", k), {24'd0, popped}, 32'(8'h20 + k));
      chk($sformatf("wrap_cnt_%0d", k), cnt(), 32'd3);
    end
    chk("wrap_wr_addr", {29'd0, wr_addr}, 32'd7);
    chk("wrap_rd_addr", {29'd0, rd_addr}, 32'd4);

    // 5a. Full with push+pop: pop accepted, push rejected.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
    chk("b_full", {31'd0, full}, 32'd1);
    cyc(1'b1, 1'b1, 8'hEE);
    chk("b_full_pop_data", {24'd0, popped}, 32'h34);
    chk("b_full_cnt", cnt(), 32'd7);
    chk("b_full_ovf", {31'd0, overflow}, 32'd1);
    chk("b_full_udf", {31'd0, underflow}, 32'd0);

    // 5b. Empty with push+pop: push accepted, pop rejected.
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    cyc(1'b1, 1'b1, 8'h55);
    chk("b_empty_cnt", cnt(), 32'd1);
    chk("b_empty_udf", {31'd0, underflow}, 32'd1);
    chk("b_empty_aempty", {31'd0, almost_empty}, 32'd1);
    chk("b_empty_ovf", {31'd0, overflow}, 32'd0);
    cyc(1'b0, 1'b1, 8'h00);
    chk("b_empty_data", {24'd0, popped}, 32'h55);

    // 6. Flush with five held and a concurrent push.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
    chk("c_cnt5", cnt(), 32'd5);
`ifdef FIFO_CTRL_LEVEL_EN
    chk("c_level5", {28'd0, level}, 32'd5);
    chk("c_thit_pre", {31'd0, thresh_hit}, 32'd1);
`endif
    clr  = 1'b1;
    push = 1'b1;
    din  = 8'h99;
    @(posedge clk);
    #1 clr = 1'b0;
    push = 1'b0;
    chk("clr_empty", {31'd0, empty}, 32'd1);
    chk("clr_wr_addr", {29'd0, wr_addr}, 32'd0);
    chk("clr_errs", {30'd0, overflow, underflow}, 32'd0);
`ifdef FIFO_CTRL_LEVEL_EN
    chk("clr_level", {28'd0, level}, 32'd0);
    @(posedge clk);
    #1;
    chk("clr_thit", {31'd0, thresh_hit}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fifo_ctrl

`default_nettype wire
